// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared constants and FSM state encoding for the trapezoid
//                scanline generator (trap_span_gen) and its divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_pkg;

    // Default coordinate width for all x/y values.
    localparam int C_COORD_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_DIVL   = 4'd1,
        ST_DIVR   = 4'd2,
        ST_NT     = 4'd3,
        ST_SPAN   = 4'd4,
        ST_WAITHI = 4'd5,
        ST_WAITLO = 4'd6,
        ST_STEP   = 4'd7,
        ST_FIN    = 4'd8
    } trap_state_t;

endpackage : trap_pkg
`default_nettype wire

// File: rtl/trap_div.sv
`default_nettype none
// ============================================================================
//  Module      : trap_div
//  Description : W-bit sequential restoring divider, one quotient bit per
//                cycle. The first step is applied directly on the start
//                cycle, so q/r are valid W cycles after start was sampled.
//  Ports       : clk, reset (async, active-low)
//                start - begin a divide of num by den (den never 0)
//                busy  - remaining steps in progress
//                q, r  - quotient and remainder, held until the next start
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_div
    import trap_pkg::*;
#(
    parameter int W = C_COORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         busy,
    output logic [W-1:0] q,
    output logic [W-1:0] r
);

    localparam int C_CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_quo;     // dividend bits shift out, quotient bits shift in
    logic [C_CW-1:0] r_cnt;

    logic [W-1:0] w_src_rem;
    logic [W-1:0] w_src_quo;
    logic [W:0]   w_trial;
    logic [W-1:0] w_diff;
    logic         w_fit;
    logic [W-1:0] w_nrem;
    logic [W-1:0] w_nquo;

    assign w_src_rem = start ? '0  : r_rem;
    assign w_src_quo = start ? num : r_quo;
    assign w_trial   = {w_src_rem, w_src_quo[W-1]};
    assign w_fit     = (w_trial >= {1'b0, den});
    // When the trial fits, the true difference is below den, so W bits suffice.
    assign w_diff    = w_trial[W-1:0] - den;
    assign w_nrem    = w_fit ? w_diff : w_trial[W-1:0];
    assign w_nquo    = {w_src_quo[W-2:0], w_fit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            r_rem <= w_nrem;
            r_quo <= w_nquo;
            r_cnt <= C_CW'(W - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            r_rem <= w_nrem;
            r_quo <= w_nquo;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == C_CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign q = r_quo;
    assign r = r_rem;

endmodule : trap_div
`default_nettype wire

// File: rtl/trap_span_gen.sv
`default_nettype none
// ============================================================================
//  Module      : trap_span_gen
//  Description : Walks a trapezoid with horizontal top/bottom edges one
//                scanline at a time, producing left/right x per line with
//                an integer DDA, paced by the output stage busy flag.
//  Ports       : clk, reset (async, active-low)
//                tv/tr                 - descriptor valid / ready (IDLE only)
//                ytop, ybot            - first/last scanline, inclusive
//                xtl, xtr, xbl, xbr    - edge x on top and bottom lines
//                po                    - output stage busy
//                xleft, xright, ynow   - current span, xs = span start pulse
//                yd, nt                - first line / new-trapezoid pulse
//                done                  - pulse after the last span
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_span_gen
    import trap_pkg::*;
#(
    parameter int W = C_COORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tv,
    output logic         tr,
    input  logic [W-1:0] ytop,
    input  logic [W-1:0] ybot,
    input  logic [W-1:0] xtl,
    input  logic [W-1:0] xtr,
    input  logic [W-1:0] xbl,
    input  logic [W-1:0] xbr,
    input  logic         po,
    output logic [W-1:0] xleft,
    output logic [W-1:0] xright,
    output logic [W-1:0] ynow,
    output logic         xs,
    output logic [W-1:0] yd,
    output logic         nt,
    output logic         done
);

    localparam int C_CW = (W > 1) ? $clog2(W) : 1;

    trap_state_t     r_state;
    logic [C_CW-1:0] r_cnt;
    logic            r_fin_hold;    // rejected descriptor: one settle cycle before done

    logic [W-1:0]    r_ytop, r_ybot, r_xtl, r_xtr, r_dy;
    logic [W-1:0]    r_abs_l, r_abs_r;
    logic            r_neg_l, r_neg_r;
    logic [W-1:0]    r_ql, r_rl, r_qr, r_rr;
    logic [W:0]      r_el, r_er;

    logic            w_div_start;
    logic [W-1:0]    w_div_num;
    logic            w_div_busy;
    logic [W-1:0]    w_div_q, w_div_r;

    logic [W:0]      w_dy_x, w_sum_l, w_sum_r, w_nel, w_ner;
    logic            w_cy_l, w_cy_r;
    logic [W-1:0]    w_stp_l, w_stp_r, w_nxl, w_nxr;

    // One divider serves both edges: left in DIVL, right in DIVR.
    assign w_div_start = ((r_state == ST_DIVL) || (r_state == ST_DIVR)) && (r_cnt == '0);
    assign w_div_num   = (r_state == ST_DIVR) ? r_abs_r : r_abs_l;

    trap_div #(.W(W)) u_div (
        .clk   (clk),
        .reset (reset),
        .start (w_div_start),
        .num   (w_div_num),
        .den   (r_dy),
        .busy  (w_div_busy),
        .q     (w_div_q),
        .r     (w_div_r)
    );

    // DDA step: the error accumulator carries the remainder; each overflow
    // past dy adds one extra unit of slope toward the bottom-edge x.
    assign w_dy_x  = {1'b0, r_dy};
    assign w_sum_l = r_el + {1'b0, r_rl};
    assign w_sum_r = r_er + {1'b0, r_rr};
    assign w_cy_l  = (w_sum_l >= w_dy_x);
    assign w_cy_r  = (w_sum_r >= w_dy_x);
    assign w_nel   = w_cy_l ? (w_sum_l - w_dy_x) : w_sum_l;
    assign w_ner   = w_cy_r ? (w_sum_r - w_dy_x) : w_sum_r;
    assign w_stp_l = r_ql + {{(W-1){1'b0}}, w_cy_l};
    assign w_stp_r = r_qr + {{(W-1){1'b0}}, w_cy_r};
    assign w_nxl   = r_neg_l ? (xleft - w_stp_l)  : (xleft + w_stp_l);
    assign w_nxr   = r_neg_r ? (xright - w_stp_r) : (xright + w_stp_r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_fin_hold <= 1'b0;
            r_ytop     <= '0;
            r_ybot     <= '0;
            r_xtl      <= '0;
            r_xtr      <= '0;
            r_dy       <= '0;
            r_abs_l    <= '0;
            r_abs_r    <= '0;
            r_neg_l    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_ql       <= '0;
            r_rl       <= '0;
            r_qr       <= '0;
            r_rr       <= '0;
            r_el       <= '0;
            r_er       <= '0;
            tr         <= 1'b1;
            xleft      <= '0;
            xright     <= '0;
            ynow       <= '0;
            yd         <= '0;
            xs         <= 1'b0;
            nt         <= 1'b0;
            done       <= 1'b0;
        end else begin
            xs   <= 1'b0;
            nt   <= 1'b0;
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tv && tr) begin
                        tr      <= 1'b0;
                        r_ytop  <= ytop;
                        r_ybot  <= ybot;
                        r_xtl   <= xtl;
                        r_xtr   <= xtr;
                        r_dy    <= ybot - ytop;
                        r_neg_l <= (xbl < xtl);
                        r_neg_r <= (xbr < xtr);
                        r_abs_l <= (xbl < xtl) ? (xtl - xbl) : (xbl - xtl);
                        r_abs_r <= (xbr < xtr) ? (xtr - xbr) : (xbr - xtr);
                        r_cnt   <= '0;
                        if (ybot < ytop) begin
                            r_state    <= ST_FIN;
                            r_fin_hold <= 1'b1;
                        end else if (ybot == ytop) begin
                            r_state <= ST_NT;
                            nt      <= 1'b1;
                            yd      <= ytop;
                            xleft   <= xtl;
                            xright  <= xtr;
                            ynow    <= ytop;
                            r_el    <= '0;
                            r_er    <= '0;
                        end else begin
                            r_state <= ST_DIVL;
                        end
                    end
                end
                ST_DIVL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_div_busy && (r_cnt == C_CW'(W - 1))) begin
                        r_cnt   <= '0;
                        r_state <= ST_DIVR;
                    end
                end
                ST_DIVR: begin
                    // Left result is still on the divider outputs in the first DIVR cycle.
                    if (r_cnt == '0) begin
                        r_ql <= w_div_q;
                        r_rl <= w_div_r;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_CW'(W - 1)) begin
                        r_state <= ST_NT;
                        nt      <= 1'b1;
                        yd      <= r_ytop;
                        xleft   <= r_xtl;
                        xright  <= r_xtr;
                        ynow    <= r_ytop;
                        r_el    <= '0;
                        r_er    <= '0;
                    end
                end
                ST_NT: begin
                    r_qr    <= w_div_q;
                    r_rr    <= w_div_r;
                    xs      <= (xleft <= xright);
                    r_state <= ST_SPAN;
                end
                ST_SPAN: begin
                    r_state <= (xleft <= xright) ? ST_WAITHI : ST_STEP;
                end
                ST_WAITHI: begin
                    if (po) r_state <= ST_WAITLO;
                end
                ST_WAITLO: begin
                    if (!po) r_state <= ST_STEP;
                end
                ST_STEP: begin
                    if (ynow == r_ybot) begin
                        r_state <= ST_FIN;
                        done    <= 1'b1;
                    end else begin
                        xleft   <= w_nxl;
                        xright  <= w_nxr;
                        r_el    <= w_nel;
                        r_er    <= w_ner;
                        ynow    <= ynow + 1'b1;
                        xs      <= (w_nxl <= w_nxr);
                        r_state <= ST_SPAN;
                    end
                end
                ST_FIN: begin
                    if (r_fin_hold) begin
                        r_fin_hold <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        tr      <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    tr      <= 1'b1;
                end
            endcase
        end
    end

endmodule : trap_span_gen
`default_nettype wire

// File: tb/tb_trap_span_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_span_gen
//  Description : Directed self-checking bench for trap_span_gen. A simple
//                output-stage model holds po high for a set number of
//                cycles after each xs; spans and pulse timings are recorded
//                relative to the descriptor accept cycle (T0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_span_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tv = 1'b0;
    logic         po = 1'b0;
    logic [W-1:0] ytop = '0, ybot = '0, xtl = '0, xtr = '0, xbl = '0, xbr = '0;
    logic         tr, xs, nt, done;
    logic [W-1:0] xleft, xright, ynow, yd;

    int checks = 0;
    int failures = 0;

    int n_sp;
    int sp_xl[16], sp_xr[16], sp_y[16], sp_t[16];
    int nt_t, nt_n, nt_yd, done_t, done_n, both_n;

    always #5 clk = ~clk;

    trap_span_gen #(.W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .tv     (tv),
        .tr     (tr),
        .ytop   (ytop),
        .ybot   (ybot),
        .xtl    (xtl),
        .xtr    (xtr),
        .xbl    (xbl),
        .xbr    (xbr),
        .po     (po),
        .xleft  (xleft),
        .xright (xright),
        .ynow   (ynow),
        .xs     (xs),
        .yd     (yd),
        .nt     (nt),
        .done   (done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge while the DUT is in IDLE.
    task automatic run_trap(input int yt, input int yb, input int tl, input int trr,
                            input int bl, input int br, input int plen, input int limit);
        int pcnt;
        n_sp = 0; nt_t = -1; nt_n = 0; nt_yd = -1;
        done_t = -1; done_n = 0; both_n = 0; pcnt = 0;
        ytop = W'(yt); ybot = W'(yb); xtl = W'(tl); xtr = W'(trr); xbl = W'(bl); xbr = W'(br);
        tv = 1'b1;
        @(posedge clk); #1;
        tv = 1'b0;
        for (int t = 1; t <= limit; t++) begin
            if (nt) begin nt_n++; nt_t = t; nt_yd = int'(yd); end
            if (xs && nt) both_n++;
            if (xs && n_sp < 16) begin
                sp_xl[n_sp] = int'(xleft); sp_xr[n_sp] = int'(xright);
                sp_y[n_sp] = int'(ynow); sp_t[n_sp] = t; n_sp++;
            end
            if (done) begin done_n++; done_t = t; end
            if (pcnt > 0) begin
                pcnt--;
                if (pcnt == 0) po = 1'b0;
            end else if (xs) begin
                po = 1'b1;
                pcnt = plen;
            end
            if (done) break;
            @(posedge clk); #1;
        end
    endtask

    // One cycle after done: done must have dropped and tr must be back.
    task automatic chk_tail(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_once"}, int'(done), 0);
        chk({tag, "_tr_back"}, int'(tr), 1);
    endtask

    initial begin
        int exl[5], exr[5];
        int seen;

        // ---------------- reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tr", int'(tr), 1);
        chk("rst_pulses", int'({nt, xs, done}), 0);
        chk("rst_coords", int'({xleft, xright, ynow, yd}), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ---------------- rectangle, po held 3 cycles
        run_trap(2, 4, 10, 13, 10, 13, 3, 200);
        chk("rect_nt_n", nt_n, 1);
        chk("rect_nt_t", nt_t, 17);
        chk("rect_yd", nt_yd, 2);
        chk("rect_nspan", n_sp, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rect_xl%0d", i), sp_xl[i], 10);
            chk($sformatf("rect_xr%0d", i), sp_xr[i], 13);
            chk($sformatf("rect_y%0d", i), sp_y[i], 2 + i);
            chk($sformatf("rect_xs_t%0d", i), sp_t[i], 18 + 5 * i);
        end
        chk("rect_both", both_n, 0);
        chk("rect_done_t", done_t, 33);
        chk_tail("rect");

        // ---------------- symmetric slope
        run_trap(0, 4, 8, 8, 0, 16, 2, 300);
        exl = '{8, 6, 4, 2, 0};
        exr = '{8, 10, 12, 14, 16};
        chk("sym_nspan", n_sp, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("sym_xl%0d", i), sp_xl[i], exl[i]);
            chk($sformatf("sym_xr%0d", i), sp_xr[i], exr[i]);
            chk($sformatf("sym_y%0d", i), sp_y[i], i);
        end
        chk("sym_done_n", done_n, 1);
        chk_tail("sym");

        // ---------------- fractional slope
        run_trap(0, 3, 0, 20, 4, 20, 2, 300);
        exl = '{0, 1, 2, 4, 0};
        chk("frac_nspan", n_sp, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("frac_xl%0d", i), sp_xl[i], exl[i]);
            chk($sformatf("frac_xr%0d", i), sp_xr[i], 20);
        end
        chk_tail("frac");

        // ---------------- single line
        run_trap(5, 5, 3, 7, 100, 200, 2, 100);
        chk("one_nt_t", nt_t, 1);
        chk("one_yd", nt_yd, 5);
        chk("one_nspan", n_sp, 1);
        chk("one_xs_t", sp_t[0], 2);
        chk("one_span", sp_xl[0] * 1000 + sp_xr[0], 3007);
        chk("one_y", sp_y[0], 5);
        chk("one_done_t", done_t, 6);
        chk_tail("one");

        // ---------------- rejected descriptor
        run_trap(6, 5, 1, 2, 3, 4, 2, 100);
        chk("rej_nt_n", nt_n, 0);
        chk("rej_nspan", n_sp, 0);
        chk("rej_done_t", done_t, 2);
        chk_tail("rej");

        // ---------------- crossed edges: last line skipped
        run_trap(0, 2, 0, 10, 10, 0, 2, 200);
        chk("cross_nspan", n_sp, 2);
        chk("cross_s0", sp_xl[0] * 1000 + sp_xr[0], 10);
        chk("cross_s1", sp_xl[1] * 1000 + sp_xr[1], 5005);
        chk("cross_y1", sp_y[1], 1);
        chk("cross_done_t", done_t, 28);
        chk_tail("cross");

        // ---------------- back-pressure: po held 50 cycles
        run_trap(2, 4, 10, 13, 10, 13, 50, 400);
        chk("bp_nspan", n_sp, 3);
        chk("bp_xs0_t", sp_t[0], 18);
        chk("bp_xs1_t", sp_t[1], 70);
        chk_tail("bp");

        // ---------------- reset while waiting for po to fall
        ytop = 8'd2; ybot = 8'd4; xtl = 8'd10; xtr = 8'd13; xbl = 8'd10; xbr = 8'd13;
        tv = 1'b1;
        @(posedge clk); #1;
        tv = 1'b0;
        for (int t = 1; t <= 40 && !xs; t++) begin
            @(posedge clk); #1;
        end
        chk("mid_xs_seen", int'(xs), 1);
        po = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_tr", int'(tr), 1);
        chk("mid_pulses", int'({nt, xs, done}), 0);
        chk("mid_coords", int'({xleft, xright, ynow, yd}), 0);
        po = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("mid_no_done", seen, 0);
        chk("mid_tr_idle", int'(tr), 1);

        run_trap(5, 5, 3, 7, 0, 0, 2, 100);
        chk("post_nt_t", nt_t, 1);
        chk("post_span", sp_xl[0] * 1000 + sp_xr[0], 3007);
        chk("post_done_t", done_t, 6);
        chk_tail("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_trap_span_gen
`default_nettype wire
